cayde_operand_fetch: RTL and testbench
======================================

# cayde_operand_fetch

Issue/operand-fetch stage directly upstream of the cayde ALU. Accepts one decoded instruction per cycle over a valid/ready handshake and reads rs1/rs2 from the architectural register file. Selects ALU operands from register, PC, immediate or zero, and presents a registered `{op, op_a, op_b, rd}` bundle to the execute stage. Owns the 32×32 register file, the writeback port, same-cycle writeback bypass, and a busy-bit scoreboard that stalls RAW and WAW hazards.

## Interface
Parameters:
- `BYPASS_EN`, default 1. When 1, a same-cycle writeback to a busy source is forwarded instead of stalling.

Ports (clock and reset first):
- `clk_i`  in  1  single clock; all state updates on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `in_valid_i`  in  1  decoded instruction valid.
- `in_ready_o`  out  1  stage can accept this cycle.
- `in_op_i`  in  `cayde_pkg::alu_op`  ALU operation.
- `in_rs1_i`, `in_rs2_i`, `in_rd_i`  in  5 each  register addresses.
- `in_rd_we_i`  in  1  instruction writes rd.
- `in_a_sel_i`  in  `cayde_pkg::opa_sel_e`  one of `OPA_RS1`, `OPA_PC`, `OPA_ZERO`.
- `in_b_sel_i`  in  `cayde_pkg::opb_sel_e`  one of `OPB_RS2`, `OPB_IMM`.
- `in_imm_i`, `in_pc_i`  in  32 each  immediate and instruction PC.
- `out_valid_o`  out  1  bundle valid to ALU stage.
- `out_ready_i`  in  1  downstream accepts bundle.
- `out_op_o`  out  `alu_op`.
- `out_op_a_o`, `out_op_b_o`  out  32 each  ALU operands.
- `out_rd_o`  out  5.
- `out_rd_we_o`  out  1.
- `wb_en_i`  in  1  writeback strobe.
- `wb_rd_i`  in  5  writeback address.
- `wb_data_i`  in  32  writeback data.
- `flush_i`  in  1  squash the held bundle and block acceptance this cycle.

## Operation
- Register file: x0 reads 0; writes to x0 are ignored; x0 is never busy.
- Source use:
  - rs1 is used iff `a_sel==OPA_RS1`.
  - rs2 is used iff `b_sel==OPB_RS2`.
  - Unused sources never stall.
- Scoreboard `busy[31:1]`:
  - Set on accept when `in_rd_we_i && rd!=0`.
  - Cleared when `wb_en_i && wb_rd_i!=0`.
  - When set and clear hit the same register in one cycle, set wins.
- Hazard: a used source that is busy, or `rd` busy with `rd_we`, stalls.
  - Exception: with `BYPASS_EN=1`, a busy register written back this cycle is not a hazard, and its source reads `wb_data_i`.
  - With `BYPASS_EN=0`, the stall lasts until the cycle after writeback.
- `in_ready_o = !flush_i && !hazard && (!out_valid_o || out_ready_i)`. This is combinational from inputs and state.
- Accept = `in_valid_i && in_ready_o`. On accept, the output register loads:
  - `op`, `rd`, `rd_we`.
  - `op_a` = rs1 value / `pc` / 0.
  - `op_b` = rs2 value / `imm`.
- Output hold: while `out_valid_o && !out_ready_i`, all `out_*` are held stable.
- Output clear: if `out_ready_i` is high and there is no accept, `out_valid_o` falls next cycle.
- Flush:
  - Next cycle, `out_valid_o=0`.
  - If the squashed bundle had `rd_we && rd!=0`, its busy bit clears, unless a writeback to that same rd sets nothing new (clear either way).
  - Register contents are unaffected; a simultaneous `wb_en_i` still writes.
- Writeback:
  - Register write happens on the edge regardless of stall or flush.
  - A read of the same register in the same cycle returns `wb_data_i` (write-through).

## Timing
- Latency: accept at edge N gives `out_valid_o=1` with the bundle from cycle N+1.
- Throughput: 1 per cycle when there are no hazards and `out_ready_i=1`.
- Reset (synchronous, wins over everything else):
  - `out_valid_o=0`.
  - All `out_*` = 0 (`out_op_o=ALU_ADD`).
  - `busy=0`.
  - All registers = 0.
  - `in_ready_o` = 1 in the first cycle after reset, given no flush.
- Reset asserted mid-operation drops any held bundle; the pending writeback is lost.
- Simultaneous accept and `out_ready_i` replaces the bundle with no bubble.
- Simultaneous flush and `in_valid_i`: no accept.

## Structure
- `cayde_pkg` gains:
  - `opa_sel_e`, `opb_sel_e`.
  - `reg_addr_t` (logic [4:0]).
  - `REG_ZERO` constant.
- Sub-module `cayde_regfile`: 31 writable 32-bit registers with synchronous reset, two combinational read ports with write-through, one write port.
- Scoreboard, hazard logic, operand mux and output register live in `cayde_operand_fetch`.

## Test plan
- Reset, then write x5=0x1234 via WB. Issue ADD with rs1=x5, b_sel=IMM, imm=1 → next cycle `out_op_a_o=0x1234`, `out_op_b_o=1`, `out_valid_o=1`.
- Issue rd=x3 with rd_we, then an instruction reading x3 while out_ready=1 → `in_ready_o=0` until WB of x3.
  - `BYPASS_EN=1`: accepted in the WB cycle with `op_a=wb_data`.
  - `BYPASS_EN=0`: accepted one cycle later.
- Hold `out_ready_i=0` for 3 cycles with `in_valid_i=1` → `in_ready_o=0` and outputs stable. Release → held bundle consumed, new bundle the next cycle, no bubble.
- rs1=x0 with WB writing x0=0xFFFF_FFFF → `op_a=0`, no stall, x0 stays 0.
- Issue rd=x7, then `flush_i` while it is held → `out_valid_o=0` next cycle and `busy[7]=0`. A following reader of x7 is accepted immediately.
- Assert `rst_i` with a valid held bundle and busy bits set → next cycle all outputs 0 and busy cleared.

Source files
------------

// File: rtl/cayde_pkg.sv
// rtl/cayde_pkg.sv - shared types and constants for the cayde pipeline
//
// Purpose: ALU op encoding, operand-select encodings, register address type.
// Ports:   none (package).
package cayde_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op;

  typedef enum logic [1:0] {
    OPA_RS1  = 2'd0,
    OPA_PC   = 2'd1,
    OPA_ZERO = 2'd2
  } opa_sel_e;

  typedef enum logic {
    OPB_RS2 = 1'b0,
    OPB_IMM = 1'b1
  } opb_sel_e;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/cayde_regfile.sv
// rtl/cayde_regfile.sv - 32x32 architectural register file, x0 hardwired to zero
//
// Purpose: 31 writable registers, one write port, two combinational read
//          ports with write-through of the same-cycle write.
// Ports:   clk_i/rst_i         clock, synchronous active-high reset
//          we_i/waddr_i/wdata_i write port (writes to x0 ignored)
//          raddr_a_i/rdata_a_o read port A
//          raddr_b_i/rdata_b_o read port B
module cayde_regfile
  import cayde_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  reg_addr_t   waddr_i,
  input  logic [31:0] wdata_i,
  input  reg_addr_t   raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  reg_addr_t   raddr_b_i,
  output logic [31:0] rdata_b_o
);

  logic [31:0] regs [31:1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (we_i && waddr_i != REG_ZERO) begin
      regs[waddr_i] <= wdata_i;
    end
  end

  // Write-through: a read of the register being written sees the new data.
  always_comb begin
    rdata_a_o = '0;
    if (raddr_a_i != REG_ZERO) begin
      if (we_i && waddr_i == raddr_a_i) rdata_a_o = wdata_i;
      else                              rdata_a_o = regs[raddr_a_i];
    end
  end

  always_comb begin
    rdata_b_o = '0;
    if (raddr_b_i != REG_ZERO) begin
      if (we_i && waddr_i == raddr_b_i) rdata_b_o = wdata_i;
      else                              rdata_b_o = regs[raddr_b_i];
    end
  end

endmodule

// File: rtl/cayde_operand_fetch.sv
// rtl/cayde_operand_fetch.sv - issue/operand-fetch stage with busy-bit scoreboard
//
// Purpose: accepts decoded instructions, reads rs1/rs2, stalls RAW/WAW
//          hazards, selects ALU operands and registers the bundle for execute.
// Ports:   clk_i/rst_i                     clock, synchronous active-high reset
//          in_valid_i/in_ready_o/in_*      decoded instruction handshake
//          out_valid_o/out_ready_i/out_*   operand bundle to the ALU stage
//          wb_en_i/wb_rd_i/wb_data_i       writeback port
//          flush_i                         squash held bundle, block accept
module cayde_operand_fetch
  import cayde_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  alu_op       in_op_i,
  input  reg_addr_t   in_rs1_i,
  input  reg_addr_t   in_rs2_i,
  input  reg_addr_t   in_rd_i,
  input  logic        in_rd_we_i,
  input  opa_sel_e    in_a_sel_i,
  input  opb_sel_e    in_b_sel_i,
  input  logic [31:0] in_imm_i,
  input  logic [31:0] in_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output alu_op       out_op_o,
  output logic [31:0] out_op_a_o,
  output logic [31:0] out_op_b_o,
  output reg_addr_t   out_rd_o,
  output logic        out_rd_we_o,
  input  logic        wb_en_i,
  input  reg_addr_t   wb_rd_i,
  input  logic [31:0] wb_data_i,
  input  logic        flush_i
);

  logic [31:0] rs1_data, rs2_data;
  logic [31:0] op_a, op_b;
  // Bit 0 is kept at zero so x0 never reads as busy without extra guards.
  logic [31:0] busy, busy_d;
  logic        rs1_haz, rs2_haz, rd_haz, hazard, accept;

  cayde_regfile u_regfile (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (wb_en_i),
    .waddr_i   (wb_rd_i),
    .wdata_i   (wb_data_i),
    .raddr_a_i (in_rs1_i),
    .rdata_a_o (rs1_data),
    .raddr_b_i (in_rs2_i),
    .rdata_b_o (rs2_data)
  );

  // A busy register being written back this cycle is forwarded when bypass
  // is enabled; the regfile write-through already supplies wb_data_i.
  always_comb begin
    rs1_haz = (in_a_sel_i == OPA_RS1) && busy[in_rs1_i] &&
              !(BYPASS_EN && wb_en_i && wb_rd_i == in_rs1_i);
    rs2_haz = (in_b_sel_i == OPB_RS2) && busy[in_rs2_i] &&
              !(BYPASS_EN && wb_en_i && wb_rd_i == in_rs2_i);
    rd_haz  = in_rd_we_i && busy[in_rd_i] &&
              !(BYPASS_EN && wb_en_i && wb_rd_i == in_rd_i);
    hazard  = rs1_haz || rs2_haz || rd_haz;
  end

  assign in_ready_o = !flush_i && !hazard && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    op_a = '0;
    case (in_a_sel_i)
      OPA_RS1: op_a = rs1_data;
      OPA_PC:  op_a = in_pc_i;
      default: op_a = '0;
    endcase
    op_b = (in_b_sel_i == OPB_IMM) ? in_imm_i : rs2_data;
  end

  // Clears first, then set, so a set on the same register wins.
  always_comb begin
    busy_d = busy;
    if (wb_en_i) busy_d[wb_rd_i] = 1'b0;
    if (flush_i && out_valid_o && out_rd_we_o) busy_d[out_rd_o] = 1'b0;
    if (accept && in_rd_we_i) busy_d[in_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy <= '0;
    else       busy <= busy_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_op_o    <= ALU_ADD;
      out_op_a_o  <= '0;
      out_op_b_o  <= '0;
      out_rd_o    <= REG_ZERO;
      out_rd_we_o <= 1'b0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      out_op_o    <= in_op_i;
      out_op_a_o  <= op_a;
      out_op_b_o  <= op_b;
      out_rd_o    <= in_rd_i;
      out_rd_we_o <= in_rd_we_i;
    end else if (flush_i || out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cayde_operand_fetch.sv
// tb/tb_cayde_operand_fetch.sv - directed scoreboard bench for cayde_operand_fetch
module tb_cayde_operand_fetch;
  import cayde_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, wb_en, flush, in_rd_we;
  alu_op       in_op;
  reg_addr_t   in_rs1, in_rs2, in_rd, wb_rd;
  opa_sel_e    in_a_sel;
  opb_sel_e    in_b_sel;
  logic [31:0] in_imm, in_pc, wb_data;

  logic        in_ready, out_valid, out_rd_we;
  alu_op       out_op;
  logic [31:0] out_op_a, out_op_b;
  reg_addr_t   out_rd;

  logic        in_ready0, out_valid0, out_rd_we0;
  alu_op       out_op0;
  logic [31:0] out_op_a0, out_op_b0;
  reg_addr_t   out_rd0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        rd_we;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  cayde_operand_fetch #(.BYPASS_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_op_i(in_op), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2), .in_rd_i(in_rd),
    .in_rd_we_i(in_rd_we), .in_a_sel_i(in_a_sel), .in_b_sel_i(in_b_sel),
    .in_imm_i(in_imm), .in_pc_i(in_pc), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_op_o(out_op), .out_op_a_o(out_op_a),
    .out_op_b_o(out_op_b), .out_rd_o(out_rd), .out_rd_we_o(out_rd_we),
    .wb_en_i(wb_en), .wb_rd_i(wb_rd), .wb_data_i(wb_data), .flush_i(flush)
  );

  cayde_operand_fetch #(.BYPASS_EN(1'b0)) dut_nobyp (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready0),
    .in_op_i(in_op), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2), .in_rd_i(in_rd),
    .in_rd_we_i(in_rd_we), .in_a_sel_i(in_a_sel), .in_b_sel_i(in_b_sel),
    .in_imm_i(in_imm), .in_pc_i(in_pc), .out_valid_o(out_valid0),
    .out_ready_i(out_ready), .out_op_o(out_op0), .out_op_a_o(out_op_a0),
    .out_op_b_o(out_op_b0), .out_rd_o(out_rd0), .out_rd_we_o(out_rd_we0),
    .wb_en_i(wb_en), .wb_rd_i(wb_rd), .wb_data_i(wb_data), .flush_i(flush)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input alu_op op, input logic [31:0] a, input logic [31:0] b,
                      input reg_addr_t rd, input logic we);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.rd = rd; e.rd_we = we;
    q.push_back(e);
  endtask

  // Compares the presented bundle against the scoreboard head.
  task automatic chk_front(input string tag, input bit do_pop);
    exp_t e;
    tests++;
    if (q.size() == 0) begin
      fails++;
      $error("FAIL %s got=empty_queue exp=entry", tag);
    end else begin
      e = q[0];
      if (do_pop) void'(q.pop_front());
      chk({tag, ".valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".op"}, 32'(out_op), 32'(e.op));
      chk({tag, ".a"}, out_op_a, e.a);
      chk({tag, ".b"}, out_op_b, e.b);
      chk({tag, ".rd"}, 32'(out_rd), 32'(e.rd));
      chk({tag, ".rd_we"}, 32'(out_rd_we), 32'(e.rd_we));
    end
  endtask

  task automatic issue(input alu_op op, input reg_addr_t rs1, input reg_addr_t rs2,
                       input reg_addr_t rd, input logic we, input opa_sel_e a,
                       input opb_sel_e b, input logic [31:0] imm, input logic [31:0] pc);
    in_valid = 1'b1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_rd_we = we; in_a_sel = a; in_b_sel = b; in_imm = imm; in_pc = pc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; wb_en = 1'b0; flush = 1'b0;
    in_op = ALU_ADD; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0; in_rd_we = 1'b0;
    in_a_sel = OPA_ZERO; in_b_sel = OPB_IMM; in_imm = '0; in_pc = '0;
    wb_rd = 5'd0; wb_data = '0;
    tick();
    do_reset();

    // Reset state
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.op", 32'(out_op), 32'(ALU_ADD));
    chk("rst.a", out_op_a, 32'd0);
    chk("rst.rd", 32'(out_rd), 32'd0);
    chk("rst.ready", 32'(in_ready), 32'd1);

    // Basic read of a written register
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
    tick();
    wb_en = 1'b0;
    issue(ALU_ADD, 5'd5, 5'd0, 5'd1, 1'b0, OPA_RS1, OPB_IMM, 32'd1, 32'h0);
    #1 chk("basic.ready", 32'(in_ready), 32'd1);
    push(ALU_ADD, 32'h1234, 32'd1, 5'd1, 1'b0);
    tick();
    in_valid = 1'b0;
    chk_front("basic", 1'b1);
    tick();
    chk("basic.drain", 32'(out_valid), 32'd0);

    // RAW hazard on x3: bypass accepts in the WB cycle, no-bypass one later
    issue(ALU_SUB, 5'd0, 5'd0, 5'd3, 1'b1, OPA_ZERO, OPB_IMM, 32'd7, 32'h40);
    push(ALU_SUB, 32'd0, 32'd7, 5'd3, 1'b1);
    tick();
    chk_front("prod", 1'b1);
    issue(ALU_ADD, 5'd3, 5'd0, 5'd0, 1'b0, OPA_RS1, OPB_IMM, 32'd2, 32'h44);
    #1 chk("raw.stall1", 32'(in_ready), 32'd0);
    tick();
    chk("raw.stall2", 32'(in_ready), 32'd0);
    chk("raw.bubble", 32'(out_valid), 32'd0);
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hCAFE;
    #1 chk("raw.byp_ready", 32'(in_ready), 32'd1);
    chk("raw.nobyp_stall", 32'(in_ready0), 32'd0);
    push(ALU_ADD, 32'hCAFE, 32'd2, 5'd0, 1'b0);
    tick();
    wb_en = 1'b0;
    chk_front("raw.byp", 1'b1);
    #1 chk("raw.nobyp_ready", 32'(in_ready0), 32'd1);
    push(ALU_ADD, 32'hCAFE, 32'd2, 5'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("raw.nobyp_valid", 32'(out_valid0), 32'd1);
    chk("raw.nobyp_a", out_op_a0, 32'hCAFE);
    chk_front("raw.byp_again", 1'b1);
    do_reset();

    // Backpressure: held bundle stable, then consumed with no bubble
    out_ready = 1'b0;
    issue(ALU_OR, 5'd0, 5'd0, 5'd0, 1'b0, OPA_PC, OPB_IMM, 32'h10, 32'h100);
    push(ALU_OR, 32'h100, 32'h10, 5'd0, 1'b0);
    tick();
    issue(ALU_XOR, 5'd0, 5'd0, 5'd2, 1'b0, OPA_ZERO, OPB_IMM, 32'h20, 32'h104);
    push(ALU_XOR, 32'd0, 32'h20, 5'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp.ready", 32'(in_ready), 32'd0);
      chk_front("bp.hold", 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("bp.release_ready", 32'(in_ready), 32'd1);
    chk_front("bp.first", 1'b1);
    tick();
    in_valid = 1'b0;
    chk_front("bp.second", 1'b1);
    tick();

    // x0 reads zero even while WB tries to write it
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
    issue(ALU_AND, 5'd0, 5'd0, 5'd0, 1'b1, OPA_RS1, OPB_RS2, 32'h0, 32'h0);
    #1 chk("x0.ready", 32'(in_ready), 32'd1);
    push(ALU_AND, 32'd0, 32'd0, 5'd0, 1'b1);
    tick();
    wb_en = 1'b0;
    chk_front("x0.same", 1'b1);
    issue(ALU_ADD, 5'd0, 5'd0, 5'd0, 1'b0, OPA_RS1, OPB_RS2, 32'h0, 32'h0);
    #1 chk("x0.ready2", 32'(in_ready), 32'd1);
    push(ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk_front("x0.after", 1'b1);
    tick();

    // Flush of held producer releases x7; flush blocks a concurrent accept
    out_ready = 1'b0;
    issue(ALU_SUB, 5'd0, 5'd0, 5'd7, 1'b1, OPA_ZERO, OPB_IMM, 32'd5, 32'h200);
    push(ALU_SUB, 32'd0, 32'd5, 5'd7, 1'b1);
    tick();
    chk_front("fl.held", 1'b1);
    issue(ALU_OR, 5'd0, 5'd0, 5'd8, 1'b1, OPA_ZERO, OPB_IMM, 32'd9, 32'h204);
    flush = 1'b1;
    #1 chk("fl.ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    chk("fl.valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    issue(ALU_ADD, 5'd7, 5'd0, 5'd0, 1'b0, OPA_RS1, OPB_IMM, 32'd3, 32'h208);
    #1 chk("fl.reader_ready", 32'(in_ready), 32'd1);
    push(ALU_ADD, 32'd0, 32'd3, 5'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk_front("fl.reader", 1'b1);
    tick();

    // Reset mid-operation: held bundle, busy bit and a pending WB all dropped
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'hAAAA;
    tick();
    wb_en = 1'b0;
    out_ready = 1'b0;
    issue(ALU_SLT, 5'd9, 5'd0, 5'd4, 1'b1, OPA_RS1, OPB_IMM, 32'd1, 32'h300);
    push(ALU_SLT, 32'hAAAA, 32'd1, 5'd4, 1'b1);
    tick();
    in_valid = 1'b0;
    chk_front("rs.held", 1'b1);
    rst = 1'b1;
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h5555;
    tick();
    rst = 1'b0; wb_en = 1'b0;
    chk("rs.valid", 32'(out_valid), 32'd0);
    chk("rs.op", 32'(out_op), 32'(ALU_ADD));
    chk("rs.a", out_op_a, 32'd0);
    chk("rs.b", out_op_b, 32'd0);
    chk("rs.rd", 32'(out_rd), 32'd0);
    chk("rs.rd_we", 32'(out_rd_we), 32'd0);
    issue(ALU_ADD, 5'd9, 5'd4, 5'd4, 1'b1, OPA_RS1, OPB_RS2, 32'h0, 32'h0);
    #1 chk("rs.ready", 32'(in_ready), 32'd1);
    push(ALU_ADD, 32'd0, 32'd0, 5'd4, 1'b1);
    tick();
    in_valid = 1'b0;
    chk_front("rs.regs_cleared", 1'b1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
